// File: rtl/glue_gate_bank_if.sv
// Pin bundle for glue_gate_bank: per-channel gate inputs, config write port,
// registered gate outputs and change pulses.
interface glue_gate_bank_if #(
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] b;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [2:0]          cfg_fn;
  logic [CHANNELS-1:0] y;
  logic [CHANNELS-1:0] chg;

  modport master (output a, b, cfg_we, cfg_ch, cfg_fn, input y, chg);
  modport slave  (input a, b, cfg_we, cfg_ch, cfg_fn, output y, chg);
endinterface

// File: rtl/glue_gate_bank.sv
// Bank of configurable two-input gates: each input is synchronised and deglitched,
// then combined by a per-channel function code into a registered output with change pulses.
module glue_gate_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned FILT_CYCLES = 3
) (
  input logic             clk,
  input logic             rst_n,
  glue_gate_bank_if.slave bus
);

  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned NB    = 2 * CHANNELS;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  localparam logic [2:0] FN_NAND = 3'b000;
  localparam logic [2:0] FN_AND  = 3'b001;
  localparam logic [2:0] FN_NOR  = 3'b010;
  localparam logic [2:0] FN_OR   = 3'b011;
  localparam logic [2:0] FN_XOR  = 3'b100;
  localparam logic [2:0] FN_XNOR = 3'b101;
  localparam logic [2:0] FN_A    = 3'b110;

  // Bits [CHANNELS-1:0] carry the A inputs, bits [NB-1:CHANNELS] the B inputs.
  logic [NB-1:0]                 s1, s2, filt, filt_nxt;
  logic [NB-1:0][CNT_W-1:0]      cnt, cnt_nxt;
  logic [CHANNELS-1:0][2:0]      fn, fn_nxt;
  logic [CHANNELS-1:0]           y_q, y_nxt, chg_q;

  function automatic logic gate(input logic [2:0] f, input logic x, input logic z);
    case (f)
      FN_NAND: gate = ~(x & z);
      FN_AND:  gate = x & z;
      FN_NOR:  gate = ~(x | z);
      FN_OR:   gate = x | z;
      FN_XOR:  gate = x ^ z;
      FN_XNOR: gate = ~(x ^ z);
      FN_A:    gate = x;
      default: gate = ~x;
    endcase
  endfunction

  // Deglitch filters, config write decode and gate evaluation.
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = cnt;
    fn_nxt   = fn;
    y_nxt    = y_q;
    for (int i = 0; i < int'(NB); i++) begin
      if (s2[i] == filt[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        filt_nxt[i] = s2[i];
        cnt_nxt[i]  = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
    // Out-of-range channel indices match no entry and are dropped.
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) fn_nxt[i] = bus.cfg_fn;
      y_nxt[i] = gate(fn[i], filt[i], filt[int'(CHANNELS) + i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      filt  <= '0;
      cnt   <= '0;
      fn    <= '0;
      y_q   <= '1;
      chg_q <= '0;
    end else begin
      s1    <= {bus.b, bus.a};
      s2    <= s1;
      filt  <= filt_nxt;
      cnt   <= cnt_nxt;
      fn    <= fn_nxt;
      chg_q <= y_nxt ^ y_q;
      y_q   <= y_nxt;
    end
  end

  assign bus.y   = y_q;
  assign bus.chg = chg_q;

endmodule

// File: tb/tb_glue_gate_bank.sv
// Scoreboard bench for glue_gate_bank: stimulus queues hand-computed expectations
// tagged with an edge number; a monitor checks them on the falling edge.
module tb_glue_gate_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned FC = 3;

  typedef struct packed {
    int       cyc;
    int       dut;
    logic [3:0] y;
    logic [3:0] ym;
    logic [3:0] c;
    logic [3:0] cm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t  q[$];
  string nm_q[$];
  logic [3:0] tt [8];

  glue_gate_bank_if #(.CHANNELS(CH)) bus ();
  glue_gate_bank_if #(.CHANNELS(3))  sbus ();

  glue_gate_bank #(.CHANNELS(CH), .FILT_CYCLES(FC)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  glue_gate_bank #(.CHANNELS(3),  .FILT_CYCLES(FC)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic expect_at(input int cyc, input string nm, input logic [3:0] y, input logic [3:0] ym,
                           input logic [3:0] c, input logic [3:0] cm, input int d = 0);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.y = y; e.ym = ym; e.c = c; e.cm = cm;
    q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic expect_win(input int from, input int to, input string nm, input logic [3:0] y,
                            input logic [3:0] ym, input logic [3:0] c, input logic [3:0] cm, input int d = 0);
    for (int k = from; k <= to; k++) expect_at(k, nm, y, ym, c, cm, d);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic cfg_set(input int ch, input int f);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 2'(ch);
    bus.cfg_fn = 3'(f);
  endtask

  // Monitor: compare every expectation due at the current edge count.
  initial forever begin
    @(negedge clk);
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].cyc <= edge_n) begin
        logic [3:0] yv, cv;
        yv = (q[k].dut == 0) ? bus.y   : {1'b0, sbus.y};
        cv = (q[k].dut == 0) ? bus.chg : {1'b0, sbus.chg};
        n_tests++;
        if (q[k].cyc < edge_n) begin
          n_fail++;
          $display("FAIL %s: check for edge %0d not reached in time (now edge %0d)", nm_q[k], q[k].cyc, edge_n);
        end else if (((yv & q[k].ym) !== (q[k].y & q[k].ym)) || ((cv & q[k].cm) !== (q[k].c & q[k].cm))) begin
          n_fail++;
          $display("FAIL %s edge %0d: got y=%h chg=%h, expected y=%h chg=%h (y mask %h, chg mask %h)",
                   nm_q[k], edge_n, yv, cv, q[k].y, q[k].c, q[k].ym, q[k].cm);
        end
        q.delete(k);
        nm_q.delete(k);
      end
    end
  end

  initial begin
    int e, n, k;
    // Truth tables indexed by {a,b}: NAND AND NOR OR XOR XNOR A ~A
    tt[0] = 4'b0111; tt[1] = 4'b1000; tt[2] = 4'b0001; tt[3] = 4'b1110;
    tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b1100; tt[7] = 4'b0011;

    rst_n = 1'b0;
    bus.a = '0; bus.b = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_fn = '0;
    sbus.a = '0; sbus.b = '0; sbus.cfg_we = 1'b0; sbus.cfg_ch = '0; sbus.cfg_fn = '0;
    expect_win(1, 2, "reset_values", 4'hF, 4'hF, 4'h0, 4'hF);
    expect_at(2, "reset_values_small", 4'h7, 4'h7, 4'h0, 4'h7, 1);
    tick(2);
    rst_n = 1'b1;

    // All inputs high: NAND outputs fall six edges later.
    e = edge_n + 1;
    bus.a = 4'hF; bus.b = 4'hF;
    expect_win(e, e + 4, "all_high_wait", 4'hF, 4'hF, 4'h0, 4'hF);
    expect_at(e + 5, "all_high_y", 4'h0, 4'hF, 4'hF, 4'hF);
    expect_at(e + 6, "all_high_chg_clear", 4'h0, 4'hF, 4'h0, 4'hF);
    tick(8);

    // Two-cycle glitch on a[0] is rejected.
    e = edge_n + 1;
    bus.a = 4'hE;
    expect_win(e, e + 8, "glitch_2cyc", 4'h0, 4'hF, 4'h0, 4'hF);
    tick(2);
    bus.a = 4'hF;
    tick(8);

    // Three-cycle low on a[0] passes, then returns.
    e = edge_n + 1;
    bus.a = 4'hE;
    expect_win(e, e + 4, "pulse_3cyc_hold", 4'h0, 4'hF, 4'h0, 4'hF);
    expect_at(e + 5, "pulse_3cyc_rise", 4'h1, 4'hF, 4'h1, 4'hF);
    expect_win(e + 6, e + 7, "pulse_3cyc_high", 4'h1, 4'hF, 4'h0, 4'hF);
    expect_at(e + 8, "pulse_3cyc_fall", 4'h0, 4'hF, 4'h1, 4'hF);
    expect_at(e + 9, "pulse_3cyc_done", 4'h0, 4'hF, 4'h0, 4'hF);
    tick(3);
    bus.a = 4'hF;
    tick(9);

    // b[2] low: NAND gives y[2]=1; then AND and XOR written to channel 2.
    e = edge_n + 1;
    bus.b = 4'hB;
    expect_at(e + 5, "b2_low_y", 4'h4, 4'hF, 4'h4, 4'hF);
    expect_at(e + 6, "b2_low_settle", 4'h4, 4'hF, 4'h0, 4'hF);
    tick(8);
    n = edge_n + 1;
    cfg_set(2, 1);
    expect_at(n, "cfg_and_old_fn", 4'h4, 4'hF, 4'h0, 4'hF);
    expect_at(n + 1, "cfg_and_applied", 4'h0, 4'hF, 4'h4, 4'hF);
    tick(1);
    bus.cfg_we = 1'b0;
    tick(1);
    n = edge_n + 1;
    cfg_set(2, 4);
    expect_at(n, "cfg_xor_old_fn", 4'h0, 4'hF, 4'h0, 4'hF);
    expect_at(n + 1, "cfg_xor_applied", 4'h4, 4'hF, 4'h4, 4'hF);
    expect_at(n + 2, "cfg_xor_settle", 4'h4, 4'hF, 4'h0, 4'hF);
    tick(1);
    bus.cfg_we = 1'b0;
    tick(2);

    // Three-channel instance: index 3 is out of range and must change nothing.
    n = edge_n + 1;
    sbus.cfg_we = 1'b1; sbus.cfg_ch = 2'd3; sbus.cfg_fn = 3'd1;
    expect_win(n, n + 3, "cfg_out_of_range", 4'h7, 4'h7, 4'h0, 4'h7, 1);
    tick(1);
    sbus.cfg_we = 1'b0;
    tick(3);
    n = edge_n + 1;
    sbus.cfg_we = 1'b1; sbus.cfg_ch = 2'd2; sbus.cfg_fn = 3'd1;
    expect_at(n + 1, "cfg_in_range_small", 4'h3, 4'h7, 4'h4, 4'h7, 1);
    tick(1);
    sbus.cfg_we = 1'b0;
    tick(2);

    // Sweep all codes on channel 1 for each input combination.
    for (int ab = 0; ab < 4; ab++) begin
      bus.a[1] = ab[1];
      bus.b[1] = ab[0];
      tick(8);
      n = edge_n + 1;
      for (int c = 0; c < 8; c++) begin
        cfg_set(1, c);
        expect_at(n + c + 1, $sformatf("sweep_fn%0d_ab%0d", c, ab), {2'b00, tt[c][ab], 1'b0}, 4'h2, 4'h0, 4'h0);
        tick(1);
      end
      bus.cfg_we = 1'b0;
      tick(2);
    end

    // Reset mid-filter with all channels set to AND and a pending rise.
    bus.a = 4'h0; bus.b = 4'h0;
    tick(8);
    for (int c = 0; c < 4; c++) begin
      cfg_set(c, 1);
      tick(1);
    end
    bus.cfg_we = 1'b0;
    tick(2);
    e = edge_n + 1;
    expect_win(e, e + 1, "pre_reset_and", 4'h0, 4'hF, 4'h0, 4'hF);
    bus.a = 4'hF; bus.b = 4'hF;
    tick(2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    k = edge_n;
    expect_at(k, "reset_immediate", 4'hF, 4'hF, 4'h0, 4'hF);
    expect_win(k + 1, k + 5, "post_reset_wait", 4'hF, 4'hF, 4'h0, 4'hF);
    expect_at(k + 6, "post_reset_nand", 4'h0, 4'hF, 4'hF, 4'hF);
    expect_at(k + 7, "post_reset_settle", 4'h0, 4'hF, 4'h0, 4'hF);
    tick(9);

    // Config write on ch0 and input change on ch3 in the same edge.
    e = edge_n + 1;
    bus.a = 4'h7;
    cfg_set(0, 1);
    expect_at(e, "simul_before", 4'h0, 4'hF, 4'h0, 4'hF);
    expect_at(e + 1, "simul_cfg", 4'h1, 4'hF, 4'h1, 4'hF);
    expect_win(e + 2, e + 4, "simul_mid", 4'h1, 4'hF, 4'h0, 4'hF);
    expect_at(e + 5, "simul_input", 4'h9, 4'hF, 4'h8, 4'hF);
    expect_at(e + 6, "simul_settle", 4'h9, 4'hF, 4'h0, 4'hF);
    tick(1);
    bus.cfg_we = 1'b0;
    tick(8);

    for (int t = 0; t < 50 && q.size() > 0; t++) tick(1);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
